// File: rtl/compression_gain_stage_if.sv
// Sample/level handshake bundle between the level detector side and the
// compression gain stage. The master drives a request with its operands; the
// slave returns the scaled sample, the applied gain and a done level.
interface compression_gain_stage_if;
  logic              start;
  logic signed [8:0] level_db;
  logic signed [7:0] audio_in;
  logic signed [7:0] audio_out;
  logic signed [8:0] gain_db;
  logic              done;

  modport master (
    output start, level_db, audio_in,
    input  audio_out, gain_db, done
  );

  modport slave (
    input  start, level_db, audio_in,
    output audio_out, gain_db, done
  );
endinterface

// File: rtl/compression_gain_stage.sv
// Static compressor gain computer and sample scaler. The gain in dB is
// split into 6 dB octaves (power-of-two shift) plus a 0..5 dB fractional
// step looked up as a Q8 mantissa; the octave count comes from a
// subtract-by-6 loop, one step per clock.
module compression_gain_stage #(
  parameter int THRESHOLD    = 20,
  parameter int RATIO_SHIFT  = 2,
  parameter int MAKE_UP_GAIN = 10
) (
  input logic                     clock,
  input logic                     reset,
  compression_gain_stage_if.slave bus
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 10;

  typedef enum logic [2:0] {IDLE, GAIN, DIV, MUL, SAT} state_t;

  state_t                    state_q, state_d;
  logic signed [8:0]         lvl_q, lvl_d;
  logic signed [DATA_W-1:0]  aud_q, aud_d;
  logic signed [8:0]         g_q, g_d;
  logic [6:0]                rem_q, rem_d;
  logic [3:0]                k_q, k_d;
  logic [2:0]                r_q, r_d;
  logic signed [4:0]         q_q, q_d;
  logic signed [23:0]        p_q, p_d;
  logic signed [DATA_W-1:0]  audio_out_q, audio_out_d;
  logic signed [8:0]         gain_db_q, gain_db_d;
  logic                      done_q, done_d;

  logic signed [10:0]        over;
  logic signed [10:0]        red;
  logic signed [11:0]        graw;

  // Limit the computed gain to the supported -48..+24 dB window.
  function automatic logic signed [8:0] clamp_gain(input logic signed [11:0] g);
    if (g > 12'sd24)       return 9'sd24;
    else if (g < -12'sd48) return -9'sd48;
    else                   return g[8:0];
  endfunction

  // Saturate a wide product down to the output sample range.
  function automatic logic signed [DATA_W-1:0] sat8(input logic signed [23:0] s);
    if (s > 24'sd127)       return 8'sd127;
    else if (s < -24'sd128) return -8'sd128;
    else                    return s[7:0];
  endfunction

  // Apply the octave shift and drop the Q8 fraction with floor rounding.
  function automatic logic signed [DATA_W-1:0] scale_sat(input logic signed [23:0] p,
                                                          input logic signed [4:0]  q);
    logic signed [23:0] s;
    logic [4:0]         sh;
    sh = '0;
    if (q >= 0) begin
      s = (p <<< q[2:0]) >>> 8;
    end else begin
      sh = 5'(5'sd8 - q);
      s  = p >>> sh;
    end
    return sat8(s);
  endfunction

  // 2^(r/6) in Q8 for the fractional dB step.
  function automatic logic [COEF_W-1:0] mant_lut(input logic [2:0] r);
    case (r)
      3'd0:    return 10'd256;
      3'd1:    return 10'd287;
      3'd2:    return 10'd323;
      3'd3:    return 10'd362;
      3'd4:    return 10'd406;
      3'd5:    return 10'd456;
      default: return 10'd256;
    endcase
  endfunction

  // Next-state and datapath updates for each FSM phase.
  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    aud_d       = aud_q;
    g_d         = g_q;
    rem_d       = rem_q;
    k_d         = k_q;
    r_d         = r_q;
    q_d         = q_q;
    p_d         = p_q;
    audio_out_d = audio_out_q;
    gain_db_d   = gain_db_q;
    done_d      = done_q;
    over        = '0;
    red         = '0;
    graw        = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          lvl_d   = bus.level_db;
          aud_d   = bus.audio_in;
          done_d  = 1'b0;
          state_d = GAIN;
        end
      end
      GAIN: begin
        over    = 11'(lvl_q) - 11'(THRESHOLD);
        red     = (over > 0) ? (over - (over >>> RATIO_SHIFT)) : 11'sd0;
        graw    = 12'(MAKE_UP_GAIN) - 12'(red);
        g_d     = clamp_gain(graw);
        rem_d   = 7'(clamp_gain(graw) + 9'sd48);
        k_d     = '0;
        state_d = DIV;
      end
      DIV: begin
        if (rem_q >= 7'd6) begin
          rem_d = rem_q - 7'd6;
          k_d   = k_q + 4'd1;
        end else begin
          r_d     = rem_q[2:0];
          q_d     = $signed({1'b0, k_q}) - 5'sd8;
          state_d = MUL;
        end
      end
      MUL: begin
        p_d     = 24'(aud_q) * $signed(24'(mant_lut(r_q)));
        state_d = SAT;
      end
      SAT: begin
        audio_out_d = scale_sat(p_q, q_q);
        gain_db_d   = g_q;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      lvl_q       <= '0;
      aud_q       <= '0;
      g_q         <= '0;
      rem_q       <= '0;
      k_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      p_q         <= '0;
      audio_out_q <= '0;
      gain_db_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      aud_q       <= aud_d;
      g_q         <= g_d;
      rem_q       <= rem_d;
      k_q         <= k_d;
      r_q         <= r_d;
      q_q         <= q_d;
      p_q         <= p_d;
      audio_out_q <= audio_out_d;
      gain_db_q   <= gain_db_d;
      done_q      <= done_d;
    end
  end

  assign bus.audio_out = audio_out_q;
  assign bus.gain_db   = gain_db_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_compression_gain_stage.sv
// Directed bench for compression_gain_stage with hand-computed vectors.
module tb_compression_gain_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  compression_gain_stage_if bus();

  compression_gain_stage dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic signed [8:0] lvl,
                        input logic signed [7:0] aud, input int exp_g,
                        input int exp_o, input int exp_lat);
    int cnt;
    bus.start    = 1'b1;
    bus.level_db = lvl;
    bus.audio_in = aud;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(cnt);
    check({tag, "_latency"}, cnt, exp_lat);
    check({tag, "_gain_db"}, bus.gain_db, exp_g);
    check({tag, "_audio_out"}, bus.audio_out, exp_o);
  endtask

  initial begin
    int cnt;
    bus.start    = 1'b0;
    bus.level_db = '0;
    bus.audio_in = '0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_audio_out", bus.audio_out, 0);
    check("reset_gain_db", bus.gain_db, 0);
    check("reset_done", bus.done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("below_thr", 9'sd10, 8'sd16, 10, 50, 13);
    run_op("compress", 9'sd60, 8'sd100, -20, 9, 8);
    run_op("sat_pos", -9'sd100, 8'sd100, 10, 127, 13);
    run_op("sat_neg", -9'sd100, -8'sd100, 10, -128, 13);
    run_op("clamp_pos", 9'sd255, 8'sd100, -48, 0, 4);
    run_op("clamp_neg", 9'sd255, -8'sd100, -48, -1, 4);

    // start pulse while busy is ignored
    bus.start = 1'b1; bus.level_db = 9'sd10; bus.audio_in = 8'sd16;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.level_db = 9'sd60; bus.audio_in = 8'sd100;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_done_low", bus.done, 0);
    check("busy_out_held", bus.audio_out, -1);
    wait_done(cnt);
    check("busy_latency", cnt, 13 - 4);
    check("busy_gain_db", bus.gain_db, 10);
    check("busy_audio_out", bus.audio_out, 50);
    @(posedge clk); #1;
    check("busy_not_queued", bus.done, 1);

    // start held high gives back-to-back operations
    bus.start = 1'b1; bus.level_db = 9'sd255; bus.audio_in = -8'sd100;
    @(posedge clk); #1;
    wait_done(cnt);
    check("b2b_first_latency", cnt, 4);
    check("b2b_first_out", bus.audio_out, -1);
    @(posedge clk); #1;
    check("b2b_done_one_cycle", bus.done, 0);
    wait_done(cnt);
    check("b2b_second_latency", cnt, 4);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("b2b_done_holds", bus.done, 1);

    // reset in the middle of the divide loop
    bus.start = 1'b1; bus.level_db = 9'sd10; bus.audio_in = 8'sd16;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_audio_out", bus.audio_out, 0);
    check("midrst_gain_db", bus.gain_db, 0);
    check("midrst_done", bus.done, 0);
    run_op("after_rst", 9'sd10, 8'sd16, 10, 50, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/compression_gain_stage.md
Name: compression_gain_stage

Overview:
- Sits directly downstream of the compressor level detector.
- Consumes the smoothed envelope level (signed dB) and one audio sample per start pulse.
- Computes static compression gain: threshold, power-of-two ratio, make-up gain, clamp.
- Converts gain to a linear multiplier via 6 dB decomposition and a sequential divide-by-6, then outputs the scaled, saturated sample to the output/DAC path.

Parameters:
- THRESHOLD, 20, compression knee in dB (signed, same scale as the level input).
- RATIO_SHIFT, 2, compression ratio = 2^RATIO_SHIFT (2 means 4:1). Legal range 0..4.
- MAKE_UP_GAIN, 10, dB added after gain reduction (signed).

Ports:
- clock  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- level_db  input  9 signed  envelope level from the level detector (dB).
- audio_in  input  8 signed  sample to be scaled; captured with start.
- audio_out  output  8 signed  scaled, saturated sample.
- gain_db  output  9 signed  applied gain after clamp, range -48..+24.
- done  output  1  level signal: high when results are valid.

Behaviour:
- Reset (synchronous, highest priority, aborts any state): state=IDLE, audio_out=0, gain_db=0, done=0, all internals=0.
- FSM states: IDLE, GAIN, DIV, MUL, SAT.
- IDLE, on start:
  - Capture level_db and audio_in; clear done; go to GAIN.
  - Without start: hold all outputs.
- GAIN:
  - over = level_db - THRESHOLD, 11-bit signed.
  - reduction = 0 if over <= 0, else over - (over >>> RATIO_SHIFT).
  - g = MAKE_UP_GAIN - reduction, clamped to [-48, +24].
  - Store g; rem = g + 48 (range 0..72); k = 0. Go to DIV.
- DIV, one step per cycle:
  - If rem >= 6: rem -= 6, k += 1, stay in DIV.
  - Else: r = rem (0..5), q = k - 8 (-8..+4); go to MUL.
- MUL:
  - mantissa = LUT[r] = {256, 287, 323, 362, 406, 456} (2^(r/6) in Q8).
  - p = audio_in * mantissa, 24-bit signed. Go to SAT.
- SAT:
  - If q >= 0: s = (p << q) >>> 8; else s = p >>> (8 - q). Arithmetic shifts, floor rounding.
  - Saturate s to [-128, 127] into audio_out; gain_db = g; done = 1. Go to IDLE.
- Latency: done rises k+4 clock edges after the edge that samples start, where k = floor((g+48)/6). Minimum 4 (g=-48), maximum 16 (g=+24).
- start while not in IDLE: ignored, not queued. Outputs and done unchanged until SAT.
- start held high: a new operation begins on every IDLE cycle. done is high for exactly the one cycle spent in IDLE before being cleared again.
- No sticky overflow state; saturation is per-sample only.

Test Plan (defaults THRESHOLD=20, RATIO_SHIFT=2, MAKE_UP_GAIN=10):
1. Below threshold: level_db=10, audio_in=16, start for 1 cycle -> gain_db=10, audio_out=50, done rises 13 edges after start.
2. Compression: level_db=60, audio_in=100 -> over=40, reduction=30, gain_db=-20, audio_out=9, latency 8.
3. Saturation: level_db=-100 with audio_in=100 -> gain_db=10, audio_out=127. Repeat with audio_in=-100 -> audio_out=-128.
4. Low clamp and floor rounding: level_db=255, audio_in=100 -> gain_db=-48, audio_out=0, latency 4. Repeat with audio_in=-100 -> audio_out=-1.
5. Busy/handshake: pulse start during DIV of scenario 1 with different inputs -> ignored, scenario 1 results unchanged. start held high -> back-to-back operations, done high 1 cycle each time.
6. Reset mid-operation: assert reset during DIV -> next edge gives audio_out=0, gain_db=0, done=0, state IDLE. A following start completes normally with the scenario 1 values.
